// File: rtl/combo_pkg.sv
// Shared constants, state encoding and vector-to-stimulus mapping for the
// combo BIST sequencer and its golden reference model.
package combo_pkg;

  localparam logic [1:0] CH_MUX = 2'b00;
  localparam logic [1:0] CH_ENC = 2'b01;
  localparam logic [1:0] CH_DEC = 2'b10;

  localparam logic [3:0] MUX_FIRST = 4'd0;
  localparam logic [3:0] ENC_FIRST = 4'd8;
  localparam logic [3:0] DEC_FIRST = 4'd12;
  localparam logic [3:0] LAST      = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] choice;
    logic       sel;
    logic       i0;
    logic       i1;
    logic [3:0] enc_in;
    logic [1:0] dec_in;
  } stim_t;

  // Stimulus for a vector index; fields not used by the selected mode stay 0.
  function automatic stim_t vec_stim(input logic [3:0] idx);
    stim_t s;
    s = '0;
    if (idx < ENC_FIRST) begin
      s.choice = CH_MUX;
      {s.sel, s.i0, s.i1} = 3'(idx - MUX_FIRST);
    end else if (idx < DEC_FIRST) begin
      s.choice = CH_ENC;
      s.enc_in = 4'b0001 << (idx - ENC_FIRST);
    end else begin
      s.choice = CH_DEC;
      s.dec_in = 2'(idx - DEC_FIRST);
    end
    return s;
  endfunction

endpackage

// File: rtl/combo_ref.sv
// Golden model of the combo block: expected mux, one-hot encoder and
// 2-to-4 decoder responses for a given stimulus.
module combo_ref (
  input  logic       sel_i,
  input  logic       i0_i,
  input  logic       i1_i,
  input  logic [3:0] enc_in_i,
  input  logic [1:0] dec_in_i,
  output logic       mux_o,
  output logic [1:0] enc_o,
  output logic [3:0] dec_o
);

  assign mux_o = sel_i ? i1_i : i0_i;
  assign dec_o = 4'b0001 << dec_in_i;

  // Priority form; only one-hot inputs are ever checked.
  always_comb begin
    enc_o = 2'd0;
    if (enc_in_i[3])      enc_o = 2'd3;
    else if (enc_in_i[2]) enc_o = 2'd2;
    else if (enc_in_i[1]) enc_o = 2'd1;
  end

endmodule

// File: rtl/combo_bist.sv
// Start-triggered self-test sequencer: walks 16 vectors through combo,
// compares each response against combo_ref and records the results.
module combo_bist
  import combo_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int FAIL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_out,
  input  logic [1:0]        enc_out,
  input  logic [3:0]        dec_out,
  output logic [1:0]        choice,
  output logic              sel,
  output logic              I0,
  output logic              I1,
  output logic [3:0]        enc_in,
  output logic [1:0]        dec_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_count,
  output logic [3:0]        first_fail
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = {FAIL_W{1'b1}};

  state_e            state_q, state_d;
  logic [3:0]        vec_q, vec_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  stim_t             stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [3:0]        first_q, first_d;

  logic       exp_mux;
  logic [1:0] exp_enc;
  logic [3:0] exp_dec;
  logic       mismatch;

  combo_ref u_ref (
    .sel_i    (stim_q.sel),
    .i0_i     (stim_q.i0),
    .i1_i     (stim_q.i1),
    .enc_in_i (stim_q.enc_in),
    .dec_in_i (stim_q.dec_in),
    .mux_o    (exp_mux),
    .enc_o    (exp_enc),
    .dec_o    (exp_dec)
  );

  // Only the response of the mode currently driven is meaningful.
  always_comb begin
    mismatch = 1'b0;
    case (stim_q.choice)
      CH_MUX:  mismatch = (mux_out != exp_mux);
      CH_ENC:  mismatch = (enc_out != exp_enc);
      CH_DEC:  mismatch = (dec_out != exp_dec);
      default: mismatch = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fail_d   = fail_q;
    first_d  = first_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          vec_d    = MUX_FIRST;
          settle_d = '0;
          stim_d   = vec_stim(MUX_FIRST);
          busy_d   = 1'b1;
          done_d   = 1'b0;
          fail_d   = '0;
          first_d  = '0;
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                         settle_d = settle_q + CNT_W'(1);
      end
      ST_CHECK: begin
        if (mismatch) begin
          // A zero count means no earlier failure, even after saturation.
          if (fail_q == '0)      first_d = vec_q;
          if (fail_q != FAIL_MAX) fail_d = fail_q + FAIL_W'(1);
        end
        if (vec_q == LAST) begin
          state_d = ST_DONE;
          stim_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_DRIVE;
          vec_d    = vec_q + 4'd1;
          settle_d = '0;
          stim_d   = vec_stim(vec_q + 4'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
    end
  end

  assign choice     = stim_q.choice;
  assign sel        = stim_q.sel;
  assign I0         = stim_q.i0;
  assign I1         = stim_q.i1;
  assign enc_in     = stim_q.enc_in;
  assign dec_in     = stim_q.dec_in;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (fail_q == '0);
  assign fail_count = fail_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_combo_bist.sv
// Self-checking bench for combo_bist: a behavioural combo with injectable
// faults answers three BIST instances (default, FAIL_W=2, SETTLE=3).
module tb_combo_bist;

  typedef struct {
    int   latency;
    logic pass;
    int   fails;
    int   first;
  } expRes_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1, start2;
  int   faultMode;
  int   dutSel;
  int   testsRun;
  int   testsFailed;

  expRes_t    resQ[$];
  logic [10:0] stimQ[$];

  logic [1:0] choice0, choice1, choice2;
  logic       sel0, sel1, sel2, ia0, ia1, ia2, ib0, ib1, ib2;
  logic [3:0] encIn0, encIn1, encIn2;
  logic [1:0] decIn0, decIn1, decIn2;
  logic       mux0, mux1, mux2;
  logic [1:0] encOut0, encOut1, encOut2;
  logic [3:0] decOut0, decOut1, decOut2;
  logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [4:0] fail0, fail2;
  logic [1:0] fail1;
  logic [3:0] first0, first1, first2;

  logic       obsBusy, obsDone, obsPass;
  logic [4:0] obsFail;
  logic [3:0] obsFirst;

  combo_bist dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .mux_out(mux0), .enc_out(encOut0), .dec_out(decOut0),
    .choice(choice0), .sel(sel0), .I0(ia0), .I1(ib0),
    .enc_in(encIn0), .dec_in(decIn0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fail0), .first_fail(first0)
  );

  combo_bist #(.FAIL_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .mux_out(mux1), .enc_out(encOut1), .dec_out(decOut1),
    .choice(choice1), .sel(sel1), .I0(ia1), .I1(ib1),
    .enc_in(encIn1), .dec_in(decIn1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fail1), .first_fail(first1)
  );

  combo_bist #(.SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .mux_out(mux2), .enc_out(encOut2), .dec_out(decOut2),
    .choice(choice2), .sel(sel2), .I0(ia2), .I1(ib2),
    .enc_in(encIn2), .dec_in(decIn2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fail2), .first_fail(first2)
  );

  // Behavioural combo: mode 1 mux stuck-at-0, 2 enc inverted,
  // 3 dec bits 0/1 swapped, 4 every output inverted.
  function automatic logic [6:0] comboModel(input int mode, input logic s, input logic a,
                                            input logic b, input logic [3:0] e,
                                            input logic [1:0] d);
    logic       m;
    logic [1:0] eo;
    logic [3:0] dOut;
    m    = s ? b : a;
    eo   = e[3] ? 2'd3 : e[2] ? 2'd2 : e[1] ? 2'd1 : 2'd0;
    dOut = 4'b0001 << d;
    case (mode)
      1: m = 1'b0;
      2: eo = ~eo;
      3: dOut = {dOut[3:2], dOut[0], dOut[1]};
      4: begin m = ~m; eo = ~eo; dOut = ~dOut; end
      default: ;
    endcase
    return {m, eo, dOut};
  endfunction

  always_comb {mux0, encOut0, decOut0} = comboModel(faultMode, sel0, ia0, ib0, encIn0, decIn0);
  always_comb {mux1, encOut1, decOut1} = comboModel(faultMode, sel1, ia1, ib1, encIn1, decIn1);
  always_comb {mux2, encOut2, decOut2} = comboModel(faultMode, sel2, ia2, ib2, encIn2, decIn2);

  always_comb begin
    obsBusy  = busy0;
    obsDone  = done0;
    obsPass  = pass0;
    obsFail  = fail0;
    obsFirst = first0;
    case (dutSel)
      1: begin
        obsBusy = busy1; obsDone = done1; obsPass = pass1;
        obsFail = {3'b000, fail1}; obsFirst = first1;
      end
      2: begin
        obsBusy = busy2; obsDone = done2; obsPass = pass2;
        obsFail = fail2; obsFirst = first2;
      end
      default: ;
    endcase
  end

  // Expected {choice, sel, I0, I1, enc_in, dec_in} for vector k.
  function automatic logic [10:0] refStim(input int k);
    logic [1:0] ch;
    logic [2:0] m;
    logic [3:0] e;
    logic [1:0] dd;
    ch = 2'b00; m = 3'b000; e = 4'b0000; dd = 2'b00;
    if (k < 8) begin
      m = k[2:0];
    end else if (k < 12) begin
      ch = 2'b01;
      e  = 4'b0001 << (k - 8);
    end else begin
      ch = 2'b10;
      dd = 2'(k - 12);
    end
    return {ch, m, e, dd};
  endfunction

  task automatic setStart(input int d, input logic v);
    case (d)
      1:       start1 = v;
      2:       start2 = v;
      default: start0 = v;
    endcase
  endtask

  // Pulses start on DUT d, pushes the expected result, then waits (bounded)
  // for done and pops/compares; optionally scoreboards every vector.
  task automatic runTest(input string tag, input int d, input int mode, input int expLat,
                         input logic expPass, input int expFails, input int expFirst,
                         input int midStart, input bit checkStim);
    expRes_t     e;
    int          cycles;
    bit          seen;
    logic [10:0] want, got;
    faultMode = mode;
    dutSel    = d;
    @(negedge clk);
    e.latency = expLat; e.pass = expPass; e.fails = expFails; e.first = expFirst;
    resQ.push_back(e);
    if (checkStim) for (int k = 0; k < 16; k++) stimQ.push_back(refStim(k));
    setStart(d, 1'b1);
    @(posedge clk); #1;
    setStart(d, 1'b0);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      setStart(d, logic'(cycles == midStart));
      if (cycles == 1) begin
        testsRun++;
        if (obsBusy !== 1'b1 || obsDone !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL %s start_response: got busy=%b done=%b, expected busy=1 done=0",
                   tag, obsBusy, obsDone);
        end
      end
      if (checkStim && (cycles % 2 == 1) && stimQ.size() > 0) begin
        want = stimQ.pop_front();
        got  = {choice0, sel0, ia0, ib0, encIn0, decIn0};
        testsRun++;
        if (got !== want) begin
          testsFailed++;
          $display("[TB] FAIL %s stim_cycle%0d: got %b, expected %b", tag, cycles, got, want);
        end
      end
      if (obsDone === 1'b1) seen = 1'b1;
    end
    setStart(d, 1'b0);
    e = resQ.pop_front();
    testsRun++;
    if (!seen) begin
      testsFailed++;
      $display("[TB] FAIL %s timeout: got no done in %0d cycles, expected done at %0d",
               tag, cycles, e.latency);
    end else begin
      if (cycles != e.latency) begin
        testsFailed++;
        $display("[TB] FAIL %s latency: got %0d, expected %0d", tag, cycles, e.latency);
      end
      testsRun++;
      if (obsPass !== e.pass || obsBusy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL %s pass_busy: got pass=%b busy=%b, expected pass=%b busy=0",
                 tag, obsPass, obsBusy, e.pass);
      end
      testsRun++;
      if (int'(obsFail) != e.fails) begin
        testsFailed++;
        $display("[TB] FAIL %s fail_count: got %0d, expected %0d", tag, obsFail, e.fails);
      end
      testsRun++;
      if (int'(obsFirst) != e.first) begin
        testsFailed++;
        $display("[TB] FAIL %s first_fail: got %0d, expected %0d", tag, obsFirst, e.first);
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    testsRun++;
    if ({busy0, done0, pass0, fail0, first0, choice0, sel0, ia0, ib0, encIn0, decIn0} !== '0 ||
        {busy1, done1, busy2, done2} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL %s outputs: got busy=%b done=%b pass=%b fails=%0d first=%0d choice=%b enc=%b dec=%b, expected all 0",
               tag, busy0, done0, pass0, fail0, first0, choice0, encIn0, decIn0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run;
    int cycles;
    faultMode = 0;
    dutSel    = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cycles = 0;
    while (cycles < 19) begin
      @(posedge clk); #1;
      cycles++;
    end
    testsRun++;
    if (choice0 !== 2'b01 || encIn0 !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL vector9_stim: got choice=%b enc_in=%b, expected choice=01 enc_in=0010",
               choice0, encIn0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkIdle("reset_mid_run");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkIdle("idle_after_reset");
    runTest("after_reset", 0, 0, 32, 1'b1, 0, 0, 0, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    faultMode   = 0;
    dutSel      = 0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    test_reset();
    runTest("golden",       0, 0, 32, 1'b1, 0,  0,  0, 1'b1);
    runTest("mux_stuck0",   0, 1, 32, 1'b0, 4,  2,  0, 1'b0);
    runTest("enc_invert",   0, 2, 32, 1'b0, 4,  8,  0, 1'b0);
    runTest("dec_swap",     0, 3, 32, 1'b0, 2,  12, 0, 1'b0);
    runTest("all_invert",   0, 4, 32, 1'b0, 16, 0,  0, 1'b0);
    runTest("saturate_w2",  1, 4, 32, 1'b0, 3,  0,  0, 1'b0);
    runTest("restart_clean",0, 0, 32, 1'b1, 0,  0,  0, 1'b0);
    test_reset_mid_run();
    runTest("start_ignored",0, 0, 32, 1'b1, 0,  0,  10, 1'b0);
    runTest("back_to_back", 0, 0, 32, 1'b1, 0,  0,  0, 1'b1);
    runTest("settle3",      2, 0, 64, 1'b1, 0,  0,  0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
